// File: rtl/frame_flusher.sv
// frame_flusher: raster scan sequencer feeding the glyph decoders and the
// VGA adapter write port.
//
// Walks every pixel of a WIDTH x HEIGHT screen in row-major order. For each
// pixel it presents the coordinate on flush_x_o/flush_y_o. It then registers
// the decoders' combinational colour/enable answer into one pixel write on
// vga_*_o, one cycle later.
//
// Ports:
//   clk_i           single clock, rising edge
//   resetn_i        synchronous active-low reset
//   start_i         frame request, honoured only while idle
//   busy_o          high while scanning and during the drain cycle
//   done_o          one-cycle pulse after the last pixel write
//   flush_x_o/y_o   coordinate presented to the glyph decoders
//   glyph_colour_i  merged decoder colour for flush_x_o/flush_y_o
//   glyph_enable_i  merged decoder enable for flush_x_o/flush_y_o
//   vga_x_o/y_o     registered write coordinate
//   vga_colour_o    registered write colour
//   vga_plot_o      write strobe
//
// Build option FRAME_FLUSHER_TRANSPARENT_EN: only glyph pixels are plotted,
// so background pixels leave the frame buffer untouched. When the macro is
// undefined, every pixel is written and the background gets BG_COLOUR.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; counters parked at (0,0)
// SCAN  | one pixel presented per cycle, previous pixel written
// DRAIN | last pixel on the write port; counters back at (0,0)
// DONE  | done pulse, no write; start ignored

module frame_flusher #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [5:0] BG_COLOUR = 6'b000000
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] flush_x_o,
  output logic [7:0] flush_y_o,
  input  logic [5:0] glyph_colour_i,
  input  logic       glyph_enable_i,
  output logic [7:0] vga_x_o,
  output logic [7:0] vga_y_o,
  output logic [5:0] vga_colour_o,
  output logic       vga_plot_o
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [5:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    // The strobe defaults low so it drops on the DRAIN->DONE edge.
    vga_plot_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_SCAN;
      end
      S_SCAN: begin
        vga_x_d      = x_q;
        vga_y_d      = y_q;
        vga_colour_d = glyph_enable_i ? glyph_colour_i : BG_COLOUR;
`ifdef FRAME_FLUSHER_TRANSPARENT_EN
        vga_plot_d   = glyph_enable_i;
`else
        vga_plot_d   = 1'b1;
`endif
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = S_DRAIN;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == S_SCAN) || (state_q == S_DRAIN);
    done_o = (state_q == S_DONE);
  end

  assign flush_x_o    = x_q;
  assign flush_y_o    = y_q;
  assign vga_x_o      = vga_x_q;
  assign vga_y_o      = vga_y_q;
  assign vga_colour_o = vga_colour_q;
  assign vga_plot_o   = vga_plot_q;

endmodule

// File: tb/tb_frame_flusher.sv
// Bench for frame_flusher: a small 4x3 instance and a full-size 160x120
// instance, each checked every cycle against a timeline model. The model
// tracks cycles elapsed since the accepted start and derives all outputs
// from that count.
module tb_frame_flusher;

  localparam int SW = 4, SH = 3, LW = 160, LH = 120;
  localparam int SN = SW * SH, LN = LW * LH;
  localparam logic [5:0] SBG = 6'h2A, LBG = 6'h15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic chk_en = 1'b0;

  logic rn_s, st_s, busy_s, done_s, plot_s, ge_s;
  logic [7:0] fx_s, fy_s, vx_s, vy_s;
  logic [5:0] vc_s, gc_s;
  logic rn_l, st_l, busy_l, done_l, plot_l, ge_l;
  logic [7:0] fx_l, fy_l, vx_l, vy_l;
  logic [5:0] vc_l, gc_l;
  int mode_s = 0, seed_s = 0, mode_l = 2, seed_l = 0;

  // glyph decoder models: 0 none, 1 single glyph at (2,1), 2 scattered pattern
  function automatic logic g_en(input int mode, input int seed, input logic [7:0] x, input logic [7:0] y);
    case (mode)
      1: return (x == 8'd2) && (y == 8'd1);
      2: return ((int'(x) * 7 + int'(y) * 13 + seed) % 5) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] g_col(input int mode, input int seed, input logic [7:0] x, input logic [7:0] y);
    if (mode == 1 && x == 8'd2 && y == 8'd1) return 6'h3F;
    return 6'(int'(x) * 5 + int'(y) * 11 + seed * 3);
  endfunction

  assign ge_s = g_en(mode_s, seed_s, fx_s, fy_s);
  assign gc_s = g_col(mode_s, seed_s, fx_s, fy_s);
  assign ge_l = g_en(mode_l, seed_l, fx_l, fy_l);
  assign gc_l = g_col(mode_l, seed_l, fx_l, fy_l);

  frame_flusher #(.WIDTH(SW), .HEIGHT(SH), .BG_COLOUR(SBG)) dut_s (
    .clk_i(clk), .resetn_i(rn_s), .start_i(st_s), .busy_o(busy_s), .done_o(done_s),
    .flush_x_o(fx_s), .flush_y_o(fy_s), .glyph_colour_i(gc_s), .glyph_enable_i(ge_s),
    .vga_x_o(vx_s), .vga_y_o(vy_s), .vga_colour_o(vc_s), .vga_plot_o(plot_s));

  frame_flusher #(.WIDTH(LW), .HEIGHT(LH), .BG_COLOUR(LBG)) dut_l (
    .clk_i(clk), .resetn_i(rn_l), .start_i(st_l), .busy_o(busy_l), .done_o(done_l),
    .flush_x_o(fx_l), .flush_y_o(fy_l), .glyph_colour_i(gc_l), .glyph_enable_i(ge_l),
    .vga_x_o(vx_l), .vga_y_o(vy_l), .vga_colour_o(vc_l), .vga_plot_o(plot_l));

  // ---------------- timeline model ----------------
  // t_m = edges since the accepted start (-1 after reset); a frame is idle
  // again once t reaches N+2.
  int         t_m [2] = '{-1, -1};
  logic [7:0] hx [2] = '{8'd0, 8'd0};
  logic [7:0] hy [2] = '{8'd0, 8'd0};
  logic [5:0] hc [2] = '{6'd0, 6'd0};
  logic       hp [2] = '{1'b0, 1'b0};

  function automatic int w_of(input int i);    return (i == 0) ? SW : LW; endfunction
  function automatic int h_of(input int i);    return (i == 0) ? SH : LH; endfunction
  function automatic int mode_of(input int i); return (i == 0) ? mode_s : mode_l; endfunction
  function automatic int seed_of(input int i); return (i == 0) ? seed_s : seed_l; endfunction
  function automatic logic [5:0] bg_of(input int i); return (i == 0) ? SBG : LBG; endfunction

  task automatic model_edge(input int i, input logic rn, input logic st);
    int n, w, p;
    logic en;
    w = w_of(i);
    n = w * h_of(i);
    if (!rn) begin
      t_m[i] = -1; hx[i] = '0; hy[i] = '0; hc[i] = '0; hp[i] = 1'b0;
    end else begin
      if (t_m[i] < 0 || t_m[i] >= n + 2) begin
        if (st) t_m[i] = 0;
      end else begin
        t_m[i] = t_m[i] + 1;
      end
      hp[i] = 1'b0;
      if (t_m[i] >= 1 && t_m[i] <= n) begin
        p = t_m[i] - 1;
        hx[i] = 8'(p % w);
        hy[i] = 8'(p / w);
        en = g_en(mode_of(i), seed_of(i), hx[i], hy[i]);
        hc[i] = en ? g_col(mode_of(i), seed_of(i), hx[i], hy[i]) : bg_of(i);
`ifdef FRAME_FLUSHER_TRANSPARENT_EN
        hp[i] = en;
`else
        hp[i] = 1'b1;
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    model_edge(0, rn_s, st_s);
    model_edge(1, rn_l, st_l);
  end

  task automatic compare(input int i, input logic [40:0] act);
    int n, w, t;
    logic [7:0] ex, ey;
    logic [40:0] req;
    w = w_of(i);
    n = w * h_of(i);
    t = t_m[i];
    ex = '0;
    ey = '0;
    if (t >= 0 && t < n) begin
      ex = 8'(t % w);
      ey = 8'(t / w);
    end
    req = {(t >= 0 && t <= n), (t == n + 1), ex, ey, hx[i], hy[i], hc[i], hp[i]};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL outputs_%0s cyc %0d busy,done,fx,fy,vx,vy,vc,plot got %h required %h",
               (i == 0) ? "small" : "large", cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare(0, {busy_s, done_s, fx_s, fy_s, vx_s, vy_s, vc_s, plot_s});
      compare(1, {busy_l, done_l, fx_l, fy_l, vx_l, vy_l, vc_l, plot_l});
    end
  end

  // ---------------- literal expectations ----------------
  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  // Runs one small frame from idle and gathers frame statistics.
  task automatic small_frame(input int mode, output int plots, output int busy_n,
                             output int dly, output int col21, output int lx, output int ly);
    int k;
    mode_s = mode;
    seed_s = int'($urandom_range(0, 1000));
    st_s = 1'b1;
    @(negedge clk);
    k = cyc;
    st_s = 1'b0;
    plots = 0; busy_n = 0; dly = -1; col21 = -1; lx = -1; ly = -1;
    for (int c = 0; c < SN + 10 && dly < 0; c++) begin
      if (plot_s) begin
        plots++;
        lx = int'(vx_s);
        ly = int'(vy_s);
        if (vx_s == 8'd2 && vy_s == 8'd1) col21 = int'(vc_s);
      end
      if (busy_s) busy_n++;
      if (done_s) dly = cyc - k;
      else @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic small_seq();
    int plots, busy_n, dly, col21, lx, ly, guard;
    repeat (10) @(negedge clk);
    lit("idle_all_zero", int'({busy_s, done_s, fx_s, fy_s, vx_s, vy_s, vc_s, plot_s} == 41'd0), 1);

    small_frame(0, plots, busy_n, dly, col21, lx, ly);
`ifdef FRAME_FLUSHER_TRANSPARENT_EN
    lit("bg_frame_plots", plots, 0);
`else
    lit("bg_frame_plots", plots, 12);
    lit("bg_frame_last_x", lx, 3);
    lit("bg_frame_last_y", ly, 2);
`endif
    lit("bg_frame_done_delay", dly, 13);
    lit("bg_frame_busy_cycles", busy_n, 13);

    small_frame(1, plots, busy_n, dly, col21, lx, ly);
    lit("glyph_colour_at_2_1", col21, 63);
`ifdef FRAME_FLUSHER_TRANSPARENT_EN
    lit("glyph_plots", plots, 1);
    lit("glyph_plot_x", lx, 2);
    lit("glyph_plot_y", ly, 1);
`else
    lit("glyph_plots", plots, 12);
`endif

    // start held high: frames back to back, checked by the model
    mode_s = 2;
    st_s = 1'b1;
    repeat (30) @(negedge clk);
    st_s = 1'b0;
    repeat (20) @(negedge clk);

    // reset while pixel 5 (1,1) is presented
    st_s = 1'b1;
    @(negedge clk);
    st_s = 1'b0;
    guard = 0;
    while (!(fx_s == 8'd1 && fy_s == 8'd1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    lit("reached_pixel5", int'(fx_s == 8'd1 && fy_s == 8'd1), 1);
    rn_s = 1'b0;
    @(negedge clk);
    lit("midscan_reset_zero", int'({busy_s, done_s, fx_s, fy_s, vx_s, vy_s, vc_s, plot_s} == 41'd0), 1);
    rn_s = 1'b1;
    @(negedge clk);
    small_frame(2, plots, busy_n, dly, col21, lx, ly);
    lit("after_reset_done_delay", dly, 13);

    // random start/reset/pattern traffic
    for (int c = 0; c < 500; c++) begin
      st_s = ($urandom_range(0, 5) == 0);
      rn_s = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 30) == 0) mode_s = int'($urandom_range(0, 2));
      if ($urandom_range(0, 30) == 0) seed_s = int'($urandom_range(0, 1000));
      @(negedge clk);
    end
    st_s = 1'b0;
    rn_s = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic large_seq();
    int k, plots, dly, lx, ly, exp_plots, exp_lx, exp_ly;
    repeat (3) @(negedge clk);
    mode_l = 2;
    seed_l = int'($urandom_range(0, 1000));
    exp_plots = 0; exp_lx = -1; exp_ly = -1;
    for (int y = 0; y < LH; y++)
      for (int x = 0; x < LW; x++) begin
`ifdef FRAME_FLUSHER_TRANSPARENT_EN
        if (g_en(mode_l, seed_l, 8'(x), 8'(y))) begin
`else
        begin
`endif
          exp_plots++;
          exp_lx = x;
          exp_ly = y;
        end
      end
    st_l = 1'b1;
    @(negedge clk);
    k = cyc;
    st_l = 1'b0;
    plots = 0; dly = -1; lx = -1; ly = -1;
    for (int c = 0; c < LN + 10 && dly < 0; c++) begin
      if (plot_l) begin
        plots++;
        lx = int'(vx_l);
        ly = int'(vy_l);
      end
      if (done_l) dly = cyc - k;
      else @(negedge clk);
    end
    lit("large_done_delay", dly, 19201);
    lit("large_plots", plots, exp_plots);
    lit("large_last_x", lx, exp_lx);
    lit("large_last_y", ly, exp_ly);
`ifndef FRAME_FLUSHER_TRANSPARENT_EN
    lit("large_plots_full", plots, 19200);
    lit("large_last_at_159_119", int'(lx == 159 && ly == 119), 1);
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rn_s = 1'b0; st_s = 1'b0;
    rn_l = 1'b0; st_l = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rn_s = 1'b1;
    rn_l = 1'b1;
    fork
      small_seq();
      large_seq();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
